// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Contents:
//   state_t : controller state encoding (IDLE, SHIFT, DONE).
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// Combinational 1-bit full-subtractor cell: diff = a - b - bin.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in from the less significant bit
//   diff : difference bit
//   bout : borrow out to the more significant bit
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when the bits match and a borrow
  // is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff_out = (a_in - b_in) mod 2^WIDTH,
// computed LSB first over WIDTH cycles through one full-subtractor cell.
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous active-high reset
//   start_in   : request, sampled only in IDLE or DONE
//   a_in, b_in : operands, captured on the accepted start edge
//   busy_out   : high while bits are being processed
//   done_out   : one-cycle completion pulse
//   diff_out   : registered difference, held until the next completion
//   borrow_out : registered final borrow (1 iff a_in < b_in)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  // Holds the WIDTH-1 bits already produced; the final bit joins on the
  // last edge when the whole word is copied to diff_out.
  logic [WIDTH-2:0]   res;
  logic               brw;
  logic [CNT_W-1:0]   cnt;
  logic               cell_d;
  logic               cell_bout;
  logic               accept;
  logic               last_bit;

  full_subtractor u_cell (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .bin  (brw),
    .diff (cell_d),
    .bout (cell_bout)
  );

  assign accept   = start_in && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_out  = 1'b0;
    done_out  = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy_out = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done_out  = 1'b1;
        state_nxt = start_in ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a       <= '0;
      op_b       <= '0;
      res        <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      op_a <= a_in;
      op_b <= b_in;
      res  <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      op_a <= op_a >> 1;
      op_b <= op_b >> 1;
      res  <= (WIDTH-1)'({cell_d, res} >> 1);
      brw  <= cell_bout;
      if (last_bit) begin
        cnt        <= '0;
        diff_out   <= {cell_d, res};
        borrow_out <= cell_bout;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic         start_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] diff_out;
  logic         borrow_out;

  int checks = 0;
  int errors = 0;
  logic [W:0] sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_in   (start_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive a one-cycle start pulse and record the expected {borrow, diff}.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in = a;
    b_in = b;
    start_in = 1'b1;
    sb.push_back({1'b0, a} - {1'b0, b});
    @(negedge clock);
    start_in = 1'b0;
  endtask

  // Wait (bounded) for done_out; report cycles waited and busy cycles seen.
  task automatic wait_done(output bit seen, output int cycles, output int busy);
    seen = 0;
    cycles = 0;
    busy = 0;
    while (!done_out && cycles < 40) begin
      if (busy_out) busy++;
      @(negedge clock);
      cycles++;
    end
    seen = done_out;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done_out not seen after %0d cycles", cycles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_in = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    checks++;
    if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_out); end
    checks++;
    if (diff_out !== '0) begin errors++; $display("FAIL reset_diff: got %h want 00", diff_out); end
    checks++;
    if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b want 0", borrow_out); end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy_out); end
  endtask

  task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    bit seen;
    int cycles, busy;
    logic [W:0] exp;
    start_op(a, b);
    wait_done(seen, cycles, busy);
    exp = sb.pop_front();
    if (seen) begin
      checks++;
      if (busy !== W) begin errors++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy, W); end
      checks++;
      if (diff_out !== exp[W-1:0]) begin errors++; $display("FAIL %s_diff: got %h want %h", name, diff_out, exp[W-1:0]); end
      checks++;
      if (borrow_out !== exp[W]) begin errors++; $display("FAIL %s_borrow: got %b want %b", name, borrow_out, exp[W]); end
    end
    @(negedge clock);
    checks++;
    if (done_out !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b want 0", name, done_out); end
  endtask

  task automatic test_basic();
    run_and_check("basic", 8'h5A, 8'h23);
  endtask

  task automatic test_underflow();
    run_and_check("under1", 8'h10, 8'h20);
    run_and_check("under2", 8'h00, 8'h01);
  endtask

  task automatic test_equal_zero();
    run_and_check("equal", 8'hA5, 8'hA5);
    run_and_check("ff_m1", 8'hFF, 8'h01);
  endtask

  task automatic test_ignored_start();
    bit seen;
    int cycles, busy, dones;
    logic [W:0] exp;
    start_op(8'h50, 8'h10);
    @(negedge clock);
    a_in = 8'h01;
    b_in = 8'h02;
    start_in = 1'b1;
    @(negedge clock);
    start_in = 1'b0;
    wait_done(seen, cycles, busy);
    exp = sb.pop_front();
    if (seen) begin
      checks++;
      if (diff_out !== exp[W-1:0]) begin errors++; $display("FAIL ign_diff: got %h want %h", diff_out, exp[W-1:0]); end
      checks++;
      if (borrow_out !== exp[W]) begin errors++; $display("FAIL ign_borrow: got %b want %b", borrow_out, exp[W]); end
    end
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done_out) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL ign_extra_done: got %0d want 0", dones); end
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("FAIL ign_idle: busy got %b want 0", busy_out); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int cycles, busy;
    logic [W:0] exp;
    a_in = 8'h80;
    b_in = 8'h01;
    start_in = 1'b1;
    sb.push_back({1'b0, a_in} - {1'b0, b_in});
    @(negedge clock);
    wait_done(seen, cycles, busy);
    exp = sb.pop_front();
    if (seen) begin
      checks++;
      if (diff_out !== exp[W-1:0]) begin errors++; $display("FAIL b2b1_diff: got %h want %h", diff_out, exp[W-1:0]); end
      checks++;
      if (borrow_out !== exp[W]) begin errors++; $display("FAIL b2b1_borrow: got %b want %b", borrow_out, exp[W]); end
    end
    a_in = 8'h03;
    b_in = 8'h04;
    sb.push_back({1'b0, a_in} - {1'b0, b_in});
    @(negedge clock);
    start_in = 1'b0;
    wait_done(seen, cycles, busy);
    exp = sb.pop_front();
    if (seen) begin
      checks++;
      if (cycles + 1 !== W + 1) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", cycles + 1, W + 1); end
      checks++;
      if (diff_out !== exp[W-1:0]) begin errors++; $display("FAIL b2b2_diff: got %h want %h", diff_out, exp[W-1:0]); end
      checks++;
      if (borrow_out !== exp[W]) begin errors++; $display("FAIL b2b2_borrow: got %b want %b", borrow_out, exp[W]); end
    end
    @(negedge clock);
  endtask

  task automatic test_reset_midop();
    bit seen;
    int cycles, busy, dones;
    logic [W:0] exp;
    start_op(8'h33, 8'h11);
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy_out); end
    checks++;
    if (done_out !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", done_out); end
    checks++;
    if (diff_out !== '0) begin errors++; $display("FAIL rmid_diff: got %h want 00", diff_out); end
    checks++;
    if (borrow_out !== 1'b0) begin errors++; $display("FAIL rmid_borrow: got %b want 0", borrow_out); end
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done_out) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d want 0", dones); end
    // Restart on the very first edge after reset is released.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start_op(8'h33, 8'h11);
    wait_done(seen, cycles, busy);
    exp = sb.pop_front();
    if (seen) begin
      checks++;
      if (busy !== W) begin errors++; $display("FAIL rst_restart_busy: got %0d want %0d", busy, W); end
      checks++;
      if (diff_out !== exp[W-1:0]) begin errors++; $display("FAIL restart_diff: got %h want %h", diff_out, exp[W-1:0]); end
      checks++;
      if (borrow_out !== exp[W]) begin errors++; $display("FAIL restart_borrow: got %b want %b", borrow_out, exp[W]); end
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_equal_zero();
    test_ignored_start();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
